stc0_egress_framer: RTL

Byte-stream transmitter that produces frames on the 8-bit `ED`/`EValid` stream format used by the stc0 core's ingress and egress ports. It accepts a frame request (word count) and then 32-bit payload words over valid/ready handshakes. It emits a framed byte sequence (SOF, length, payload MSB-first, XOR checksum) that an stc0 ingress port consumes unchanged. It sits between on-chip producers (or the test harness) and any `ID`/`IValid` sink.

---
 rtl/stc0_pkg.sv | 6 +
 rtl/stc0_word_ser.sv | 38 +++
 rtl/stc0_egress_framer.sv | 101 ++++++++++
 3 files changed

// File: rtl/stc0_pkg.sv
// stc0_pkg: shared constants and frame-state type for stc0 byte-stream blocks
package stc0_pkg;
    localparam logic [7:0]  STC0_SOF         = 8'hA5;
    localparam int unsigned STC0_GAP_DEFAULT = 2;
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_PAY, S_CSUM, S_GAP} stc0_efrm_state_t;
endpackage

// File: rtl/stc0_word_ser.sv
// stc0_word_ser: 32-to-8 word serializer, MSB byte first, with gapless reload on the last byte
module stc0_word_ser (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        more,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic [7:0]  data,
    output logic        vld,
    output logic        last
);
    logic [31:0] sr;
    logic [1:0]  idx;
    logic        full;
    // an empty register passes the incoming word's top byte straight through
    assign data   = full ? sr[31:24] : wdata[31:24];
    assign vld    = en && (full || wvalid);
    assign last   = en && full && idx == 2'd3;
    assign wready = en && (!full || (last && more));
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sr   <= '0;
            idx  <= '0;
            full <= 1'b0;
        end else if (vld) begin
            if (wready && wvalid) begin
                sr   <= full ? wdata : {wdata[23:0], 8'h00};
                idx  <= full ? 2'd0 : 2'd1;
                full <= 1'b1;
            end else begin
                sr   <= {sr[23:0], 8'h00};
                idx  <= idx + 2'd1;
                full <= !last;
            end
        end
endmodule

// File: rtl/stc0_egress_framer.sv
// stc0_egress_framer: frames requested 32-bit payload words as SOF, length, payload, XOR checksum
module stc0_egress_framer
    import stc0_pkg::*;
#(
    parameter logic [7:0]  SOF = STC0_SOF,
    parameter int unsigned GAP = STC0_GAP_DEFAULT
) (
    input  logic        ClkEgress,
    input  logic        ARst,
    input  logic        SValid,
    input  logic [7:0]  SLen,
    output logic        SReady,
    input  logic [31:0] WData,
    input  logic        WValid,
    output logic        WReady,
    output logic [7:0]  ED,
    output logic        EValid,
    output logic        Busy
);
    stc0_efrm_state_t state_q, state_d;
    logic [7:0] len_q, len_d, words_left, left_d, csum, csum_d, ed_d, b_data;
    logic [3:0] gap_cnt, gap_d;
    logic       ev_d, more, b_vld, b_last;

    assign more   = words_left > 8'd1;
    assign SReady = state_q == S_IDLE;
    assign Busy   = !SReady;

    stc0_word_ser u_ser (
        .clk(ClkEgress), .rst(ARst), .en(state_q == S_PAY), .more(more),
        .wdata(WData), .wvalid(WValid), .wready(WReady),
        .data(b_data), .vld(b_vld), .last(b_last)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        left_d  = words_left;
        csum_d  = csum;
        gap_d   = gap_cnt;
        ed_d    = ED;
        ev_d    = 1'b0;
        case (state_q)
            S_IDLE: if (SValid && SLen != 8'd0) begin
                len_d   = SLen;
                left_d  = SLen;
                state_d = S_HDR;
            end
            S_HDR: begin
                ed_d    = SOF;
                ev_d    = 1'b1;
                state_d = S_LEN;
            end
            S_LEN: begin
                ed_d    = len_q;
                ev_d    = 1'b1;
                csum_d  = len_q;
                state_d = S_PAY;
            end
            S_PAY: if (b_vld) begin
                ed_d   = b_data;
                ev_d   = 1'b1;
                csum_d = csum ^ b_data;
                if (b_last) begin
                    left_d  = words_left - 8'd1;
                    state_d = more ? S_PAY : S_CSUM;
                end
            end
            S_CSUM: begin
                ed_d    = csum;
                ev_d    = 1'b1;
                gap_d   = '0;
                state_d = (GAP == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                gap_d   = gap_cnt + 4'd1;
                state_d = (gap_cnt == 4'(GAP - 1)) ? S_IDLE : S_GAP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ClkEgress or posedge ARst)
        if (ARst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            words_left <= '0;
            csum       <= '0;
            gap_cnt    <= '0;
            ED         <= '0;
            EValid     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            words_left <= left_d;
            csum       <= csum_d;
            gap_cnt    <= gap_d;
            ED         <= ed_d;
            EValid     <= ev_d;
        end
endmodule
